// File: rtl/io_bus_bridge.sv
// ---------------------------------------------------------------------------
// io_bus_bridge
//
// Bridges a single-outstanding CPU IO request onto an 8-slot device bus.
// CpuAddr[6:4] picks the device slot and CpuAddr[3:0] the register. A request
// to a populated slot selects that device until it acks or the access times
// out. A request to an empty slot errors at once. Every transaction ends with
// a one-cycle CpuAck pulse. CpuErr qualifies that pulse.
//
// Parameters
//   SLOT_ENABLE    : one bit per slot, 1 = populated
//   TIMEOUT_CYCLES : max ACCESS cycles before an error (1..255)
//
// Ports
//   Clock, Reset          : rising-edge clock, async active-high reset
//   CpuReq/Write/Addr/WData: CPU request, held until CpuAck
//   CpuRData/Ack/Err       : registered response
//   IoSel                 : one-hot device select, high only during ACCESS
//   IoWrite/RegAddr/WData : request fields latched when the request is taken
//   IoRData, IoAck        : per-slot read data (32b each) and acknowledge
//   ErrAddr               : CpuAddr of the most recent errored transaction
//
// All outputs come straight from flops. No combinational path runs from any
// input to any output.
// ---------------------------------------------------------------------------
module io_bus_bridge #(
    parameter logic [7:0]  SLOT_ENABLE    = 8'b0000_1011,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         CpuReq,
    input  logic         CpuWrite,
    input  logic [6:0]   CpuAddr,
    input  logic [31:0]  CpuWData,
    output logic [31:0]  CpuRData,
    output logic         CpuAck,
    output logic         CpuErr,
    output logic [7:0]   IoSel,
    output logic         IoWrite,
    output logic [3:0]   IoRegAddr,
    output logic [31:0]  IoWData,
    input  logic [255:0] IoRData,
    input  logic [7:0]   IoAck,
    output logic [6:0]   ErrAddr
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    // The last ACCESS cycle is the one where the counter reads TIMEOUT_CYCLES-1.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [2:0]     slot, slot_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;

    logic [31:0]    rdata_nxt;
    logic           ack_nxt, err_nxt;
    logic [7:0]     sel_nxt;
    logic           write_nxt;
    logic [3:0]     regaddr_nxt;
    logic [31:0]    wdata_nxt;
    logic [6:0]     erraddr_nxt;

    // Only the selected slot's ack and read word matter. The other IoAck bits
    // never reach the FSM.
    logic           slot_ack;
    logic [31:0]    slot_rdata;

    assign slot_ack   = IoAck[slot];
    assign slot_rdata = IoRData[{slot, 5'd0} +: 32];

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            slot      <= 3'd0;
            cnt       <= '0;
            CpuRData  <= 32'd0;
            CpuAck    <= 1'b0;
            CpuErr    <= 1'b0;
            IoSel     <= 8'd0;
            IoWrite   <= 1'b0;
            IoRegAddr <= 4'd0;
            IoWData   <= 32'd0;
            ErrAddr   <= 7'd0;
        end else begin
            state     <= state_nxt;
            slot      <= slot_nxt;
            cnt       <= cnt_nxt;
            CpuRData  <= rdata_nxt;
            CpuAck    <= ack_nxt;
            CpuErr    <= err_nxt;
            IoSel     <= sel_nxt;
            IoWrite   <= write_nxt;
            IoRegAddr <= regaddr_nxt;
            IoWData   <= wdata_nxt;
            ErrAddr   <= erraddr_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic.
    // The registered outputs are computed one cycle early from the state
    // being entered. This way IoSel is high exactly during ACCESS, and
    // CpuAck/CpuErr are high exactly during RESP.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        slot_nxt    = slot;
        cnt_nxt     = cnt;
        rdata_nxt   = CpuRData;
        ack_nxt     = 1'b0;
        err_nxt     = 1'b0;
        sel_nxt     = 8'd0;
        write_nxt   = IoWrite;
        regaddr_nxt = IoRegAddr;
        wdata_nxt   = IoWData;
        erraddr_nxt = ErrAddr;

        case (state)
            IDLE: begin
                if (CpuReq) begin
                    slot_nxt    = CpuAddr[6:4];
                    regaddr_nxt = CpuAddr[3:0];
                    write_nxt   = CpuWrite;
                    wdata_nxt   = CpuWData;
                    cnt_nxt     = '0;
                    if (SLOT_ENABLE[CpuAddr[6:4]]) begin
                        state_nxt = ACCESS;
                        sel_nxt   = 8'b1 << CpuAddr[6:4];
                    end else begin
                        // Empty slot: skip ACCESS and respond next cycle.
                        state_nxt   = RESP;
                        ack_nxt     = 1'b1;
                        err_nxt     = 1'b1;
                        rdata_nxt   = 32'd0;
                        erraddr_nxt = CpuAddr;
                    end
                end
            end

            ACCESS: begin
                if (slot_ack) begin
                    // An ack wins over a timeout that falls in the same cycle.
                    state_nxt = RESP;
                    ack_nxt   = 1'b1;
                    rdata_nxt = IoWrite ? 32'd0 : slot_rdata;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = RESP;
                    ack_nxt     = 1'b1;
                    err_nxt     = 1'b1;
                    rdata_nxt   = 32'd0;
                    erraddr_nxt = {slot, IoRegAddr};
                    cnt_nxt     = cnt + CW'(1);
                end else begin
                    cnt_nxt = cnt + CW'(1);
                    sel_nxt = IoSel;
                end
            end

            RESP: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_io_bus_bridge.sv
// ---------------------------------------------------------------------------
// tb_io_bus_bridge
//
// Directed and random transactions against io_bus_bridge. The reference model
// has no notion of FSM states. For each transaction it works out the expected
// outcome from the address, the cycle on which the device acks, the slot
// enable mask and the timeout:
//   - error flag
//   - number of cycles IoSel stays high
//   - CpuAck latency
//   - read data
//   - ErrAddr
// ---------------------------------------------------------------------------
module tb_io_bus_bridge;

    localparam logic [7:0] SLOT_EN = 8'b0000_1011;
    localparam int         TMO     = 16;

    logic         Clock = 1'b0;
    logic         Reset = 1'b1;
    logic         CpuReq = 1'b0;
    logic         CpuWrite = 1'b0;
    logic [6:0]   CpuAddr = 7'd0;
    logic [31:0]  CpuWData = 32'd0;
    logic [31:0]  CpuRData;
    logic         CpuAck;
    logic         CpuErr;
    logic [7:0]   IoSel;
    logic         IoWrite;
    logic [3:0]   IoRegAddr;
    logic [31:0]  IoWData;
    logic [255:0] IoRData = '0;
    logic [7:0]   IoAck = 8'd0;
    logic [6:0]   ErrAddr;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [6:0] model_erraddr = 7'd0;

    io_bus_bridge #(
        .SLOT_ENABLE   (SLOT_EN),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .CpuReq   (CpuReq),
        .CpuWrite (CpuWrite),
        .CpuAddr  (CpuAddr),
        .CpuWData (CpuWData),
        .CpuRData (CpuRData),
        .CpuAck   (CpuAck),
        .CpuErr   (CpuErr),
        .IoSel    (IoSel),
        .IoWrite  (IoWrite),
        .IoRegAddr(IoRegAddr),
        .IoWData  (IoWData),
        .IoRData  (IoRData),
        .IoAck    (IoAck),
        .ErrAddr  (ErrAddr)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rand_rdata();
        for (int i = 0; i < 8; i++) IoRData[32*i +: 32] = $urandom;
    endtask

    // Run one transaction. The task is entered and left 1 time unit after a
    // rising edge.
    //   ack_at = ACCESS cycle (1-based) on which IoAck[slot] is driven; 0 = never.
    //   stray  = IoAck bits driven on other slots throughout.
    task automatic run_txn(input string tag, input logic [6:0] addr, input logic wr,
                           input logic [31:0] wd, input int ack_at, input logic [7:0] stray);
        logic [2:0]  slot;
        logic [7:0]  onehot;
        logic [31:0] rd_word;
        int          sel_cyc, ack_edge;
        bit          sel_bad, acked, exp_err;
        int          exp_sel;
        logic [31:0] exp_rd;
        logic        got_err;
        logic [31:0] got_rd;
        logic [6:0]  got_ea;

        slot     = addr[6:4];
        onehot   = 8'd1 << slot;
        rd_word  = IoRData[32*slot +: 32];
        sel_cyc  = 0;
        ack_edge = 0;
        sel_bad  = 0;
        got_err  = 1'b0;
        got_rd   = 32'd0;
        got_ea   = 7'd0;

        CpuReq   = 1'b1;
        CpuWrite = wr;
        CpuAddr  = addr;
        CpuWData = wd;
        IoAck    = stray & ~onehot;

        for (int e = 1; e <= 40 && ack_edge == 0; e++) begin
            @(posedge Clock); #1;
            CpuReq = 1'b0;
            if (CpuAck) begin
                ack_edge = e;
                got_err  = CpuErr;
                got_rd   = CpuRData;
                got_ea   = ErrAddr;
                if (IoSel != 8'd0) sel_bad = 1;
            end
            if (IoSel != 8'd0) begin
                sel_cyc++;
                if (IoSel !== onehot) sel_bad = 1;
            end
            IoAck = stray & ~onehot;
            if (IoSel != 8'd0 && sel_cyc == ack_at) IoAck[slot] = 1'b1;
        end

        // Reference outcome
        acked   = SLOT_EN[slot] && ack_at >= 1 && ack_at <= TMO;
        exp_err = !acked;
        exp_sel = !SLOT_EN[slot] ? 0 : (acked ? ack_at : TMO);
        exp_rd  = (acked && !wr) ? rd_word : 32'd0;
        if (exp_err) model_erraddr = addr;

        chk({tag, ".ack_lat"}, ack_edge, exp_sel + 1);
        chk({tag, ".err"},     got_err, exp_err);
        chk({tag, ".rdata"},   got_rd, exp_rd);
        chk({tag, ".erraddr"}, got_ea, model_erraddr);
        chk({tag, ".sel_cyc"}, sel_cyc, exp_sel);
        chk({tag, ".sel_val"}, sel_bad, 1'b0);
        chk({tag, ".regaddr"}, IoRegAddr, addr[3:0]);
        chk({tag, ".iowrite"}, IoWrite, wr);
        chk({tag, ".iowdata"}, IoWData, wd);

        // The ack is a single-cycle pulse, and CpuReq is low by now.
        @(posedge Clock); #1;
        chk({tag, ".ack_pulse"}, CpuAck, 1'b0);
        IoAck = 8'd0;
    endtask

    initial begin
        int acks;

        // Reset values
        repeat (3) @(posedge Clock);
        #1;
        chk("rst.sel", IoSel, 8'd0);
        chk("rst.ack", {CpuAck, CpuErr}, 2'b00);
        chk("rst.rdata", CpuRData, 32'd0);
        chk("rst.io", {IoWrite, IoRegAddr, IoWData}, 37'd0);
        chk("rst.erraddr", ErrAddr, 7'd0);
        Reset = 1'b0;

        // Read from slot 3, acked on the first ACCESS cycle
        IoRData = '0;
        IoRData[32*3 +: 32] = 32'hCAFE_0001;
        run_txn("rd", 7'h31, 1'b0, 32'h0, 1, 8'h00);
        chk("rd.cafe", CpuRData, 32'hCAFE_0001);

        // Write to slot 1, acked on the third ACCESS cycle
        rand_rdata();
        run_txn("wr", 7'h10, 1'b1, 32'h0000_00A5, 3, 8'h00);

        // Empty slot
        run_txn("rsv", 7'h52, 1'b0, 32'h1234_5678, 1, 8'h00);
        chk("rsv.ea", ErrAddr, 7'h52);

        // Timeout on slot 0
        run_txn("tmo", 7'h00, 1'b0, 32'h0, 0, 8'h00);
        chk("tmo.ea", ErrAddr, 7'h00);

        // Ack in the final ACCESS cycle still wins
        rand_rdata();
        run_txn("last", 7'h07, 1'b0, 32'h0, TMO, 8'h00);

        // Ack on slot 1 while slot 3 is selected is ignored
        run_txn("stray", 7'h3C, 1'b1, 32'hDEAD_BEEF, 0, 8'h02);

        // Reset in the middle of ACCESS
        CpuReq = 1'b1; CpuWrite = 1'b1; CpuAddr = 7'h35; CpuWData = 32'h5555_AAAA;
        @(posedge Clock); #1;
        CpuReq = 1'b0;
        @(posedge Clock); #1;
        chk("mid.sel_before", IoSel, 8'h08);
        #2 Reset = 1'b1;
        #1;
        chk("mid.sel", IoSel, 8'd0);
        chk("mid.ack", {CpuAck, CpuErr}, 2'b00);
        chk("mid.regs", {CpuRData, IoWrite, IoRegAddr, IoWData, ErrAddr}, 76'd0);
        model_erraddr = 7'd0;
        @(posedge Clock); #1;
        Reset = 1'b0;
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clock); #1;
            if (CpuAck) acks++;
        end
        chk("mid.no_ack", acks, 0);
        rand_rdata();
        run_txn("post_rst", 7'h31, 1'b0, 32'h0, 2, 8'h00);

        // Random traffic
        for (int n = 0; n < 40; n++) begin
            rand_rdata();
            run_txn("rnd", 7'($urandom), 1'($urandom), $urandom,
                    int'($urandom_range(0, TMO + 2)), 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/io_bus_bridge.md
IO_BUS_BRIDGE -- requirements
Module: io_bus_bridge

Interface
REQ-001 SHALL have parameter SLOT_ENABLE, default 8'b0000_1011, one bit per 3-bit device slot; 1 means the slot is populated (EIC, BKD, STMR).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, the maximum number of cycles to wait for a device ack; legal range 1..255.
REQ-003 SHALL have port Clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port CpuReq, input, 1, CPU IO request, held until CpuAck.
REQ-006 SHALL have port CpuWrite, input, 1, 1 = write, 0 = read.
REQ-007 SHALL have port CpuAddr, input, 7, where [6:4] is the device slot and [3:0] is the register address.
REQ-008 SHALL have port CpuWData, input, 32, write data.
REQ-009 SHALL have port CpuRData, output, 32, registered read data.
REQ-010 SHALL have port CpuAck, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port CpuErr, output, 1, error qualifier, valid only when CpuAck=1.
REQ-012 SHALL have port IoSel, output, 8, one-hot device select.
REQ-013 SHALL have port IoWrite, output, 1, latched write flag.
REQ-014 SHALL have port IoRegAddr, output, 4, latched register address.
REQ-015 SHALL have port IoWData, output, 32, latched write data.
REQ-016 SHALL have port IoRData, input, 256, read data from all slots, where slot n occupies bits [32n+31:32n].
REQ-017 SHALL have port IoAck, input, 8, per-slot device acknowledge.
REQ-018 SHALL have port ErrAddr, output, 7, the CpuAddr of the most recent errored transaction.

Function
REQ-019 SHALL implement the FSM states IDLE, ACCESS and RESP.
REQ-020 SHALL sample CpuReq only in IDLE; CpuReq is ignored in ACCESS and RESP.
REQ-021 SHALL, in IDLE with CpuReq=1, latch CpuAddr, CpuWrite and CpuWData into IoRegAddr, IoWrite, IoWData and an internal slot register.
REQ-022 SHALL, on that same IDLE request, go to ACCESS if SLOT_ENABLE[slot]=1, otherwise go directly to RESP with error.
REQ-023 SHALL drive IoSel[slot]=1 only while in ACCESS; IoSel=0 in IDLE and RESP.
REQ-024 SHALL clear the timeout counter on entry to ACCESS and increment it by 1 each ACCESS cycle with no ack.
REQ-025 SHALL size the timeout counter at $clog2(TIMEOUT_CYCLES+1) bits.
REQ-026 SHALL, in ACCESS with IoAck[slot]=1, go to RESP with no error.
REQ-027 SHALL, on a read completing that way, capture IoRData[slot] into CpuRData.
REQ-028 SHALL, on a write completing that way, load 0 into CpuRData.
REQ-029 SHALL, in ACCESS with no ack and counter = TIMEOUT_CYCLES-1, go to RESP with error; ACCESS therefore lasts at most TIMEOUT_CYCLES cycles.
REQ-030 SHALL give the ack priority when IoAck[slot] and the timeout condition occur in the same cycle: no error.
REQ-031 SHALL ignore IoAck bits of non-selected slots in every state.
REQ-032 SHALL ignore all IoAck bits in IDLE and RESP.
REQ-033 SHALL, on any error, load CpuRData with 0 and ErrAddr with the latched address.
REQ-034 SHALL hold ErrAddr until the next error.
REQ-035 SHALL, in RESP, drive CpuAck=1 for exactly one cycle with CpuErr valid, then go to IDLE.
REQ-036 SHALL drive CpuAck=0 and CpuErr=0 in every state other than RESP.
REQ-037 SHALL complete an enabled access acked on the first ACCESS cycle with CpuAck asserted 2 cycles after the request is sampled.
REQ-038 SHALL complete a disabled-slot access with CpuAck asserted 1 cycle after the request is sampled.
REQ-039 SHALL start a new transaction on the cycle after RESP if CpuReq is still 1; the CPU must deassert CpuReq after CpuAck.
REQ-040 SHALL register all outputs, with no combinational path from inputs to outputs.

Reset
REQ-041 SHALL, on Reset=1 at any time including mid-ACCESS, force the FSM to IDLE and the counter to 0.
REQ-042 SHALL, on Reset=1, force IoSel=0, CpuAck=0 and CpuErr=0.
REQ-043 SHALL, on Reset=1, force CpuRData=0, IoWrite=0, IoRegAddr=0, IoWData=0 and ErrAddr=0.
REQ-044 SHALL accept no request until the first rising Clock edge after Reset deasserts.

Verification
REQ-045 SHALL cover a read: CpuAddr=7'h31, IoAck[3]=1 in the first ACCESS cycle, IoRData slot 3 = 32'hCAFE_0001 -> IoSel=8'h08 for 1 cycle, IoRegAddr=4'h1, CpuAck 2 cycles after the request, CpuErr=0, CpuRData=32'hCAFE_0001.
REQ-046 SHALL cover a write: CpuAddr=7'h10, CpuWData=32'h0000_00A5, IoAck[1] after 3 cycles -> IoWrite=1, IoWData=32'hA5, IoSel=8'h02 for 3 cycles, CpuErr=0, CpuRData=0.
REQ-047 SHALL cover a reserved slot: CpuAddr=7'h52 -> IoSel stays 0, CpuAck 1 cycle later with CpuErr=1, ErrAddr=7'h52, CpuRData=0.
REQ-048 SHALL cover timeout: CpuAddr=7'h00 with no ack and TIMEOUT_CYCLES=16 -> IoSel=8'h01 for exactly 16 cycles, then CpuAck=1, CpuErr=1, ErrAddr=7'h00.
REQ-049 SHALL cover boundary conditions: IoAck[0] arrives in the 16th ACCESS cycle -> CpuErr=0; IoAck[1] pulsed while slot 3 is selected -> ignored, still times out.
REQ-050 SHALL cover reset mid-operation: Reset asserted during ACCESS -> IoSel=0 immediately, no CpuAck, next request after reset handled normally.
